// File: rtl/risc16_pkg.sv
// Shared definitions for the RISC-16 multi-cycle core: opcode values,
// controller state encoding, ALU operand-mux / function encodings,
// register-file write-select codes, the registered control bundle and a
// sign-extension helper for the 7-bit immediate.
package risc16_pkg;

  // Opcodes, taken from ir[15:13]
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_ADDI = 3'b001;
  localparam logic [2:0] OP_NAND = 3'b010;
  localparam logic [2:0] OP_LUI  = 3'b011;
  localparam logic [2:0] OP_SW   = 3'b100;
  localparam logic [2:0] OP_LW   = 3'b101;
  localparam logic [2:0] OP_BEQ  = 3'b110;
  localparam logic [2:0] OP_JALR = 3'b111;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  // ALU function select
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_NAND  = 2'b01;
  localparam logic [1:0] ALU_PASS1 = 2'b10;
  localparam logic [1:0] ALU_ZERO  = 2'b11;

  // ALU operand muxes
  localparam logic [1:0] SRC1_REG = 2'b00;
  localparam logic [1:0] SRC1_LUI = 2'b01;
  localparam logic [1:0] SRC2_REG = 2'b00;
  localparam logic [1:0] SRC2_IMM = 2'b01;

  // Register file write-data select
  localparam logic [1:0] WSEL_ALU = 2'b00;
  localparam logic [1:0] WSEL_MEM = 2'b01;
  localparam logic [1:0] WSEL_PC  = 2'b10;

  // Every control output of the controller, held in one register so the
  // whole set is Moore-registered and cleared together by reset.
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_sel;
    logic [1:0] mux_alu1;
    logic [1:0] mux_alu2;
    logic [1:0] func_alu;
    logic       rf_we;
    logic [1:0] rf_wsel;
    logic       halted;
    logic       err;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  function automatic logic [15:0] sext7(input logic [6:0] imm);
    return {{9{imm[6]}}, imm};
  endfunction

endpackage

// File: rtl/risc16_pc_unit.sv
// Program counter for the RISC-16 multi-cycle core.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset (pc <= RESET_PC)
//   inc           advance pc by one (instruction fetch accepted)
//   branch        taken beq: pc <= pc + sext(branch_imm)
//   jump          jalr: pc <= jump_target
//   branch_imm    7-bit branch offset from the instruction register
//   jump_target   jalr target (register file port 1)
//   pc            current program counter
// Priority is jump > branch > inc; the controller never asserts more than
// one in the same cycle. All additions wrap at 16 bits.
module risc16_pc_unit
  import risc16_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  input  logic        branch,
  input  logic        jump,
  input  logic [6:0]  branch_imm,
  input  logic [15:0] jump_target,
  output logic [15:0] pc
);

  logic [15:0] pc_q;
  logic [15:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (jump) begin
      pc_d = jump_target;
    end else if (branch) begin
      // pc was already incremented at fetch, so the offset is relative to pc+1
      pc_d = pc_q + sext7(branch_imm);
    end else if (inc) begin
      pc_d = pc_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/risc16_mc_ctrl.sv
// Multi-cycle control unit for the RISC-16 core. Owns the instruction
// register and (through risc16_pc_unit) the PC, and sequences the shared
// ALU through FETCH / DECODE / EXEC / MEM / WB, with a terminal HALT.
//
// Memory handshake: mem_req is the request valid; once raised it is held,
// together with mem_addr_sel and mem_we, until a cycle in which mem_ready=1.
// That cycle completes the transfer and mem_rdata is sampled on its rising
// edge. mem_ready is ignored while mem_req=0. A reset may abandon a request.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   mem_rdata, mem_ready  memory read data / completion
//   alu_eq                ALU equality flag for beq
//   rf_src1               register file port 1 (jalr target)
//   mem_req, mem_we       memory request / write strobe (sw)
//   mem_addr_sel          0 = pc, 1 = ALU result
//   ir, pc                instruction register, program counter
//   mux_alu1, mux_alu2    ALU operand selects
//   func_alu              ALU function
//   rf_we, rf_wsel        register file write enable / data select
//   halted, err           core stopped / memory timeout seen
//   state_dbg             current controller state (state_t encoding)
//
// All control outputs come from one register loaded with the values of the
// state being entered, so they are stable for the whole state and all read
// zero during reset. A consequence is that the very first FETCH after reset
// spends one cycle with mem_req=0 before the request goes out.
module risc16_mc_ctrl
  import risc16_pkg::*;
#(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  // 0 = wait forever on memory; otherwise cycles (max 65535) before HALT+err
  parameter int unsigned WAIT_LIMIT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  input  logic        alu_eq,
  input  logic [15:0] rf_src1,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic [15:0] ir,
  output logic [15:0] pc,
  output logic [1:0]  mux_alu1,
  output logic [1:0]  mux_alu2,
  output logic [1:0]  func_alu,
  output logic        rf_we,
  output logic [1:0]  rf_wsel,
  output logic        halted,
  output logic        err,
  output logic [2:0]  state_dbg
);

  localparam bit          WAIT_EN   = (WAIT_LIMIT != 0);
  localparam logic [15:0] WAIT_LAST = 16'(WAIT_LIMIT - 1);

  state_t      state_q, state_d;
  ctrl_t       ctrl_q, ctrl_d;
  logic [15:0] ir_q;
  logic [15:0] wait_q, wait_d;
  logic [2:0]  opcode;
  logic        mem_done;
  logic        timeout;
  logic        ir_load;
  logic        pc_inc;
  logic        branch;
  logic        jump;

  assign opcode   = ir_q[15:13];
  assign mem_done = ctrl_q.mem_req & mem_ready;
  // Final unanswered cycle of a request: the wait budget is used up
  assign timeout  = WAIT_EN & ctrl_q.mem_req & ~mem_ready & (wait_q == WAIT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      ctrl_q  <= CTRL_IDLE;
      ir_q    <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      wait_q  <= wait_d;
      if (ir_load) begin
        ir_q <= mem_rdata;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ctrl_d  = CTRL_IDLE;
    ir_load = 1'b0;
    pc_inc  = 1'b0;
    branch  = 1'b0;
    jump    = 1'b0;

    // Next state
    unique case (state_q)
      ST_FETCH: begin
        if (mem_done) begin
          ir_load = 1'b1;
          pc_inc  = 1'b1;
          state_d = ST_DECODE;
        end else if (timeout) begin
          state_d = ST_HALT;
        end
      end
      ST_DECODE: begin
        // jalr with a nonzero immediate field is the halt encoding
        if (opcode == OP_JALR && ir_q[6:0] != 7'd0) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (opcode)
          OP_SW, OP_LW: state_d = ST_MEM;
          OP_BEQ: begin
            branch  = alu_eq;
            state_d = ST_FETCH;
          end
          OP_JALR: begin
            // rf_src1 is sampled this edge, before the link write lands
            jump    = 1'b1;
            state_d = ST_FETCH;
          end
          default: state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        if (mem_done) begin
          state_d = (opcode == OP_LW) ? ST_WB : ST_FETCH;
        end else if (timeout) begin
          state_d = ST_HALT;
        end
      end
      ST_WB:   state_d = ST_FETCH;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_HALT;
    endcase

    // Registered outputs for the state being entered
    unique case (state_d)
      ST_FETCH: begin
        ctrl_d.mem_req = 1'b1;
      end
      ST_EXEC: begin
        case (opcode)
          OP_ADDI, OP_SW, OP_LW: begin
            ctrl_d.mux_alu1 = SRC1_REG;
            ctrl_d.mux_alu2 = SRC2_IMM;
            ctrl_d.func_alu = ALU_ADD;
          end
          OP_NAND: begin
            ctrl_d.mux_alu1 = SRC1_REG;
            ctrl_d.mux_alu2 = SRC2_REG;
            ctrl_d.func_alu = ALU_NAND;
          end
          OP_LUI: begin
            ctrl_d.mux_alu1 = SRC1_LUI;
            ctrl_d.mux_alu2 = SRC2_REG;
            ctrl_d.func_alu = ALU_PASS1;
          end
          OP_JALR: begin
            ctrl_d.rf_we   = 1'b1;
            ctrl_d.rf_wsel = WSEL_PC;
          end
          default: begin
            // add, beq: register operands, adder
            ctrl_d.mux_alu1 = SRC1_REG;
            ctrl_d.mux_alu2 = SRC2_REG;
            ctrl_d.func_alu = ALU_ADD;
          end
        endcase
      end
      ST_MEM: begin
        // ALU keeps producing the address computed in EXEC
        ctrl_d.mux_alu1     = ctrl_q.mux_alu1;
        ctrl_d.mux_alu2     = ctrl_q.mux_alu2;
        ctrl_d.func_alu     = ctrl_q.func_alu;
        ctrl_d.mem_req      = 1'b1;
        ctrl_d.mem_addr_sel = 1'b1;
        ctrl_d.mem_we       = (opcode == OP_SW);
      end
      ST_WB: begin
        ctrl_d.mux_alu1 = ctrl_q.mux_alu1;
        ctrl_d.mux_alu2 = ctrl_q.mux_alu2;
        ctrl_d.func_alu = ctrl_q.func_alu;
        ctrl_d.rf_we    = 1'b1;
        ctrl_d.rf_wsel  = (opcode == OP_LW) ? WSEL_MEM : WSEL_ALU;
      end
      ST_HALT: begin
        ctrl_d.halted = 1'b1;
        ctrl_d.err    = ctrl_q.err | timeout;
      end
      default: ;
    endcase

    // Wait counter: consecutive unanswered request cycles within one state
    if (state_d != state_q) begin
      wait_d = '0;
    end else if (WAIT_EN && ctrl_q.mem_req && !mem_ready) begin
      wait_d = wait_q + 16'd1;
    end else begin
      wait_d = wait_q;
    end
  end

  risc16_pc_unit #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk         (clk),
    .rst_n       (rst_n),
    .inc         (pc_inc),
    .branch      (branch),
    .jump        (jump),
    .branch_imm  (ir_q[6:0]),
    .jump_target (rf_src1),
    .pc          (pc)
  );

  assign mem_req      = ctrl_q.mem_req;
  assign mem_we       = ctrl_q.mem_we;
  assign mem_addr_sel = ctrl_q.mem_addr_sel;
  assign mux_alu1     = ctrl_q.mux_alu1;
  assign mux_alu2     = ctrl_q.mux_alu2;
  assign func_alu     = ctrl_q.func_alu;
  assign rf_we        = ctrl_q.rf_we;
  assign rf_wsel      = ctrl_q.rf_wsel;
  assign halted       = ctrl_q.halted;
  assign err          = ctrl_q.err;
  assign ir           = ir_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_risc16_mc_ctrl.sv
// Bench for risc16_mc_ctrl. The bench plays the memory and the datapath
// (alu_eq, rf_src1) and predicts, per instruction, the cycle count, strobe
// counts, write-select, ALU settings and next pc from the ISA-level rules.
module tb_risc16_mc_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic        alu_eq;
  logic [15:0] rf_src1;

  logic        mem_req, mem_we, mem_addr_sel, rf_we, halted, err;
  logic [15:0] ir, pc;
  logic [1:0]  mux_alu1, mux_alu2, func_alu, rf_wsel;
  logic [2:0]  state_dbg;

  logic        mem_req_t, mem_we_t, mem_addr_sel_t, rf_we_t, halted_t, err_t;
  logic [15:0] ir_t, pc_t;
  logic [1:0]  mux_alu1_t, mux_alu2_t, func_alu_t, rf_wsel_t;
  logic [2:0]  state_dbg_t;

  risc16_mc_ctrl dut (
    .clk(clk), .rst_n(rst_n), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .alu_eq(alu_eq), .rf_src1(rf_src1), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr_sel(mem_addr_sel), .ir(ir), .pc(pc), .mux_alu1(mux_alu1),
    .mux_alu2(mux_alu2), .func_alu(func_alu), .rf_we(rf_we), .rf_wsel(rf_wsel),
    .halted(halted), .err(err), .state_dbg(state_dbg)
  );

  // Second instance: finite memory wait budget, memory never answers
  risc16_mc_ctrl #(.WAIT_LIMIT(8)) dut_to (
    .clk(clk), .rst_n(rst_n), .mem_rdata(16'h0000), .mem_ready(1'b0),
    .alu_eq(1'b0), .rf_src1(16'h0000), .mem_req(mem_req_t), .mem_we(mem_we_t),
    .mem_addr_sel(mem_addr_sel_t), .ir(ir_t), .pc(pc_t), .mux_alu1(mux_alu1_t),
    .mux_alu2(mux_alu2_t), .func_alu(func_alu_t), .rf_we(rf_we_t), .rf_wsel(rf_wsel_t),
    .halted(halted_t), .err(err_t), .state_dbg(state_dbg_t)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0] pc_m;   // architectural pc of the reference model

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_all_idle(input string tag);
    check({tag, "_ctrl"}, {mem_req, mem_we, mem_addr_sel, rf_we, halted, err,
                           mux_alu1, mux_alu2, func_alu, rf_wsel}, 0);
    check({tag, "_pc"}, pc, 16'h0000);
    check({tag, "_ir"}, ir, 16'h0000);
  endtask

  // ---------------- driver + model per instruction ----------------
  // Called at a negedge where the DUT is issuing (or about to issue) a fetch.
  // fd/md: cycles the memory withholds mem_ready on fetch / data access.
  task automatic run_instr(input logic [15:0] instr, input int fd, input int md,
                           input logic eq, input logic [15:0] src1);
    logic [2:0]  op;
    logic        is_halt;
    int          exp_cycles, exp_rfwe, exp_memwe, exp_dreq;
    logic [1:0]  exp_wsel;
    logic [15:0] exp_pc, exp_wpc;
    logic [5:0]  exp_alu, alu_mask;
    int          cyc, fk, mk, acc, rfwe_n, memwe_n, dreq_n;
    logic [1:0]  wsel_seen;
    logic [15:0] wpc_seen;
    logic [5:0]  alu_seen;
    logic        done;

    // ---- reference model ----
    op       = instr[15:13];
    is_halt  = (op == 3'd7) && (instr[6:0] != 7'd0);
    exp_pc   = pc_m + 16'd1;
    exp_wpc  = 16'h0000;
    exp_rfwe = 0; exp_memwe = 0; exp_dreq = 0; exp_wsel = 2'd0;
    exp_alu  = 6'd0; alu_mask = 6'h3F;
    if (is_halt) begin
      exp_cycles = 1 + fd + 1;
      alu_mask   = 6'd0;
    end else begin
      case (op)
        3'd4: begin exp_cycles = 1 + fd + 2 + 1 + md; exp_memwe = 1 + md; exp_dreq = 1 + md; end
        3'd5: begin exp_cycles = 1 + fd + 2 + 1 + md + 1; exp_dreq = 1 + md; exp_rfwe = 1; exp_wsel = 2'd1; end
        3'd6: begin
          exp_cycles = 1 + fd + 2;
          if (eq) exp_pc = pc_m + 16'd1 + {{9{instr[6]}}, instr[6:0]};
        end
        3'd7: begin exp_cycles = 1 + fd + 2; exp_rfwe = 1; exp_wsel = 2'd2; exp_pc = src1; exp_wpc = pc_m + 16'd1; end
        default: begin exp_cycles = 1 + fd + 3; exp_rfwe = 1; end
      endcase
      // {mux_alu1, mux_alu2, func_alu}
      case (op)
        3'd1, 3'd4, 3'd5: exp_alu = 6'b00_01_00;
        3'd2:             exp_alu = 6'b00_00_01;
        3'd3: begin       exp_alu = 6'b01_00_10; alu_mask = 6'b11_00_11; end
        3'd6:             alu_mask = 6'b11_11_00;
        3'd7:             alu_mask = 6'b00_00_00;
        default:          exp_alu = 6'b00_00_00;
      endcase
    end

    // ---- drive memory and observe, one iteration per cycle ----
    alu_eq = eq; rf_src1 = src1;
    cyc = 0; fk = 0; mk = 0; acc = -1; rfwe_n = 0; memwe_n = 0; dreq_n = 0;
    wsel_seen = 2'd0; wpc_seen = 16'h0000; alu_seen = 6'd0; done = 1'b0;
    while (!done && cyc < 200) begin
      mem_ready = 1'b0;
      if (halted || (acc >= 0 && mem_req && !mem_addr_sel)) begin
        done = 1'b1;
      end else begin
        if (mem_req && !mem_addr_sel) begin
          if (fk == fd) begin mem_ready = 1'b1; mem_rdata = instr; acc = cyc; end
          else fk++;
        end
        if (mem_req && mem_addr_sel) begin
          dreq_n++;
          if (mem_we) memwe_n++;
          if (mk == md) begin mem_ready = 1'b1; mem_rdata = 16'($urandom); end
          else mk++;
        end
        if (rf_we) begin rfwe_n++; wsel_seen = rf_wsel; wpc_seen = pc; end
        if (acc >= 0 && cyc == acc + 2) alu_seen = {mux_alu1, mux_alu2, func_alu};
        cyc++;
        @(negedge clk);
      end
    end

    check("instr_done", done, 1'b1);
    check("cycles", cyc, exp_cycles);
    check("halted", halted, is_halt);
    check("pc_after", pc, exp_pc);
    check("ir", ir, instr);
    check("rf_we_count", rfwe_n, exp_rfwe);
    check("mem_we_count", memwe_n, exp_memwe);
    check("data_req_count", dreq_n, exp_dreq);
    if (exp_rfwe != 0) check("rf_wsel", wsel_seen, exp_wsel);
    if (alu_mask != 6'd0) check("alu_exec", alu_seen & alu_mask, exp_alu & alu_mask);
    if (op == 3'd7 && !is_halt) check("jalr_link_pc", wpc_seen, exp_wpc);
    pc_m = exp_pc;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int req_cycles;
    int hits;
    logic [2:0]  op;
    logic [15:0] instr;

    rst_n = 1'b0; mem_ready = 1'b0; mem_rdata = 16'h0000; alu_eq = 1'b0; rf_src1 = 16'h0000;
    pc_m = 16'h0000;
    repeat (3) @(negedge clk);
    check_all_idle("reset");
    check("reset_to_ctrl", {mem_req_t, halted_t, err_t}, 3'b000);

    // Timeout instance: memory silent, 8 request cycles then HALT with err
    rst_n = 1'b1;
    req_cycles = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (halted_t) break;
      if (mem_req_t) req_cycles++;
    end
    check("to_req_cycles", req_cycles, 8);
    check("to_halted", halted_t, 1'b1);
    check("to_err", err_t, 1'b1);
    check("to_req_dropped", mem_req_t, 1'b0);
    // Default instance waits forever on the same silent memory
    repeat (12) @(negedge clk);
    check("wait_forever_req", mem_req, 1'b1);
    check("wait_forever_flags", {halted, err}, 2'b00);

    // ALU / memory ops from pc 0
    run_instr(16'h2405, 0, 0, 1'b0, 16'h0000);  // addi r1,r0,5
    run_instr(16'hA882, 0, 3, 1'b0, 16'h0000);  // lw, data ready after 3 waits
    run_instr(16'h8882, 0, 0, 1'b0, 16'h0000);  // sw, ready at once
    run_instr(16'h0A43, 2, 0, 1'b0, 16'h0000);  // add, fetch delayed
    run_instr(16'h4A43, 1, 0, 1'b0, 16'h0000);  // nand
    run_instr(16'h6C55, 0, 0, 1'b0, 16'h0000);  // lui
    // beq at 0x0010 taken (-2) and not taken
    run_instr(16'hEE00, 0, 0, 1'b0, 16'h0010);
    run_instr(16'hC07E, 0, 0, 1'b1, 16'h0000);
    run_instr(16'hEE00, 0, 0, 1'b0, 16'h0010);
    run_instr(16'hC07E, 0, 0, 1'b0, 16'h0000);
    // jalr at 0x0020 to 0x1234
    run_instr(16'hEE00, 0, 0, 1'b0, 16'h0020);
    run_instr(16'hEE00, 0, 0, 1'b0, 16'h1234);
    // pc wrap at 0xFFFF
    run_instr(16'hEE00, 0, 0, 1'b0, 16'hFFFF);
    run_instr(16'h2405, 0, 0, 1'b0, 16'h0000);

    // Randomized instruction stream (halt encoding excluded)
    for (int n = 0; n < 40; n++) begin
      op    = 3'($urandom_range(0, 7));
      instr = {op, 13'($urandom)};
      if (op == 3'd7) instr[6:0] = 7'd0;
      run_instr(instr, $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), 16'($urandom));
    end

    // Halt encoding: jalr with imm=1, then no requests for 20 cycles
    run_instr(16'hEE01, 0, 0, 1'b0, 16'h0000);
    req_cycles = 0;
    repeat (20) begin
      @(negedge clk);
      if (mem_req) req_cycles++;
    end
    check("halt_no_req", req_cycles, 0);
    check("halt_sticky", {halted, err}, 2'b10);

    // Reset asserted in the middle of a data access
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mem_ready = 1'b1; mem_rdata = 16'hA882;   // lw, never completes its MEM
    @(negedge clk);
    mem_ready = 1'b0;
    hits = 0;
    for (int k = 0; k < 10; k++) begin
      if (mem_req && mem_addr_sel) begin hits = 1; break; end
      @(negedge clk);
    end
    check("mid_mem_reached", hits, 1);
    #2 rst_n = 1'b0;
    #1 check_all_idle("reset_mid_mem");
    #1 rst_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
